// File: rtl/hilo_divider_pkg.sv
// rtl/hilo_divider_pkg.sv - shared types for the HI/LO iterative divider
package hilo_divider_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_RUN,
    DIV_DONE
  } div_state_t;

  typedef struct packed {
    logic                 op_signed;
    logic [DIV_WIDTH-1:0] a;
    logic [DIV_WIDTH-1:0] b;
  } div_req_t;

  typedef struct packed {
    logic [DIV_WIDTH-1:0] hi;
    logic [DIV_WIDTH-1:0] lo;
  } div_resp_t;

endpackage

// File: rtl/hilo_divider_div_step.sv
// rtl/hilo_divider_div_step.sv - one combinational restoring-division step
module hilo_divider_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;

  // The extra top bit keeps the compare exact when rem's MSB shifts out.
  assign shifted  = {rem, dividend_bit};
  assign q_bit    = (shifted >= {1'b0, divisor});
  assign rem_next = q_bit ? WIDTH'(shifted - {1'b0, divisor}) : WIDTH'(shifted);

endmodule

// File: rtl/hilo_divider.sv
// rtl/hilo_divider.sv - multi-cycle DIV/DIVU unit producing {hi, lo}
module hilo_divider
  import hilo_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  div_state_t     state, state_next;
  logic [CW-1:0]  count;
  logic [WIDTH-1:0] divd, dsr, rem;
  logic           sign_q, sign_r;
  logic [WIDTH-1:0] hi_r, lo_r;

  logic             accept, last_step, a_neg, b_neg, q_bit;
  logic [WIDTH-1:0] mag_a, mag_b, rem_nxt, q_final;

  assign accept    = (state == DIV_IDLE) && in_valid && !flush;
  assign last_step = (count == CW'(WIDTH - 1));
  assign a_neg     = op_signed & a[WIDTH-1];
  assign b_neg     = op_signed & b[WIDTH-1];
  assign mag_a     = a_neg ? -a : a;
  assign mag_b     = b_neg ? -b : b;

  // divd doubles as the quotient register: dividend bits leave at the top
  // while quotient bits enter at the bottom.
  hilo_divider_div_step #(.WIDTH(WIDTH)) u_step (
    .rem          (rem),
    .dividend_bit (divd[WIDTH-1]),
    .divisor      (dsr),
    .rem_next     (rem_nxt),
    .q_bit        (q_bit)
  );

  assign q_final = {divd[WIDTH-2:0], q_bit};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= DIV_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      DIV_IDLE: if (accept) state_next = DIV_RUN;
      DIV_RUN: begin
        if (flush)          state_next = DIV_IDLE;
        else if (last_step) state_next = DIV_DONE;
      end
      DIV_DONE: if (flush || out_ready) state_next = DIV_IDLE;
      default: state_next = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count  <= '0;
      divd   <= '0;
      dsr    <= '0;
      rem    <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
    end else if (accept) begin
      count  <= '0;
      divd   <= mag_a;
      dsr    <= mag_b;
      rem    <= '0;
      sign_q <= a_neg ^ b_neg;
      sign_r <= a_neg;
    end else if (state == DIV_RUN) begin
      count <= count + CW'(1);
      divd  <= q_final;
      rem   <= rem_nxt;
      if (last_step) begin
        lo_r <= sign_q ? -q_final : q_final;
        hi_r <= sign_r ? -rem_nxt : rem_nxt;
      end
    end
  end

  assign in_ready  = (state == DIV_IDLE);
  assign out_valid = (state == DIV_DONE);
  assign busy      = (state != DIV_IDLE);
  assign hi        = hi_r;
  assign lo        = lo_r;

endmodule

// File: tb/tb_hilo_divider.sv
// tb/tb_hilo_divider.sv - randomized self-checking bench for hilo_divider
module tb_hilo_divider;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        op_signed = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] hi, lo;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  hilo_divider #(.WIDTH(32)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_signed (op_signed),
    .a         (a),
    .b         (b),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference: MIPS semantics from plain integer arithmetic.
  task automatic model(input logic sgn, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] ehi, output logic [31:0] elo);
    longint sx, sy, q, r;
    if (y == 0) begin
      ehi = x;
      elo = (sgn && x[31]) ? 32'd1 : 32'hFFFF_FFFF;
    end else if (!sgn) begin
      elo = x / y;
      ehi = x % y;
    end else begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      q = sx / sy;
      r = sx % sy;
      elo = q[31:0];
      ehi = r[31:0];
    end
  endtask

  task automatic issue(input logic sgn, input logic [31:0] x, input logic [31:0] y);
    @(posedge clk); #1;
    check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; op_signed = sgn; a = x; b = y;
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom;
  endtask

  task automatic run_op(input string tag, input logic sgn, input logic [31:0] x,
                        input logic [31:0] y, input int hold);
    logic [31:0] ehi, elo, hi0, lo0;
    int lat;
    bit busy_ok, stable;
    model(sgn, x, y, ehi, elo);
    issue(sgn, x, y);
    lat = 1;
    busy_ok = 1'b1;
    while (!out_valid && lat < 100) begin
      if (!busy || in_ready) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (!busy || in_ready) busy_ok = 1'b0;
    check({tag, "_latency"}, 32'(lat), 32'd33);
    check({tag, "_busy_in_ready"}, {31'd0, busy_ok}, 32'd1);
    check({tag, "_lo"}, lo, elo);
    check({tag, "_hi"}, hi, ehi);
    hi0 = hi; lo0 = lo;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (!out_valid || in_ready || hi !== hi0 || lo !== lo0) stable = 1'b0;
    end
    if (hold > 0) check({tag, "_backpressure_stable"}, {31'd0, stable}, 32'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_in_ready_after"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_out_valid_after"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic rs;
    int seen;

    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    @(posedge clk); @(posedge clk); #2;
    resetn = 1'b1;

    run_op("divu_100_7", 1'b0, 32'd100, 32'd7, 5);
    run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("divu_5_0", 1'b0, 32'd5, 32'd0, 1);
    run_op("div_m8_0", 1'b1, 32'hFFFF_FFF8, 32'd0, 0);
    run_op("div_7_0", 1'b1, 32'd7, 32'd0, 0);

    // Flush in cycle 10 of the operation.
    issue(1'b0, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);
    check("flush_busy", {31'd0, busy}, 32'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("flush_no_result", 32'(seen), 32'd0);
    run_op("divu_9_3", 1'b0, 32'd9, 32'd3, 0);

    // Reset in cycle 15 of the operation.
    issue(1'b1, 32'hFFFF_0000, 32'd77);
    repeat (14) @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    check("midrun_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrun_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrun_rst_busy", {31'd0, busy}, 32'd0);
    check("midrun_rst_hi", hi, 32'd0);
    check("midrun_rst_lo", lo, 32'd0);
    @(posedge clk); #2;
    resetn = 1'b1;

    // Flush beats in_valid in IDLE.
    @(posedge clk); #1;
    flush = 1'b1; in_valid = 1'b1; op_signed = 1'b0; a = 32'd50; b = 32'd5;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("idle_flush_in_ready", {31'd0, in_ready}, 32'd1);
    check("idle_flush_busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 24; i++) begin
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: begin ra = $urandom; rb = $urandom; end
        1: begin ra = $urandom; rb = $urandom_range(0, 20); end
        2: begin ra = $urandom_range(0, 1000); rb = $urandom; end
        default: begin ra = $urandom; rb = {{16{1'($urandom_range(0, 1))}}, 16'($urandom)}; end
      endcase
      run_op($sformatf("rand%0d", i), rs, ra, rb, $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hilo_divider.md
Name: hilo_divider

Overview:
Multi-cycle iterative divider that executes the DIV/DIVU operations the decoder marks with a HILO write of both halves (hilo_write_en=2'b11) and a MULT-result write-back value. It sits beside the execute stage: the pipeline issues operands over a valid/ready handshake, stalls while the divider is busy, and collects {hi, lo} over a second handshake. Remainder goes to HI and quotient goes to LO, per MIPS.

Parameters:
WIDTH, 32, operand/result width; also the iteration count.

Ports:
clk  in  1  clock.
resetn  in  1  asynchronous active-low reset.
in_valid  in  1  operands and op present.
in_ready  out  1  divider can accept (high only in IDLE).
op_signed  in  1  1 = DIV (signed), 0 = DIVU.
a  in  WIDTH  dividend (rs).
b  in  WIDTH  divisor (rt).
flush  in  1  synchronous abort (exception/branch squash).
out_valid  out  1  result held on hi/lo.
out_ready  in  1  consumer takes result.
hi  out  WIDTH  remainder.
lo  out  WIDTH  quotient.
busy  out  1  state != IDLE; drives the pipeline stall.

Behaviour:
- Reset (async, resetn=0): state=IDLE, counter=0, datapath registers 0. Outputs: in_ready=1, out_valid=0, busy=0, hi=0, lo=0.
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid & in_ready & !flush, latch the following, then go to RUN with counter=0:
  - |a| and |b| (two's-complement magnitude if op_signed and the MSB is set, else the raw value);
  - sign_q = op_signed & (a[MSB]^b[MSB]);
  - sign_r = op_signed & a[MSB].
- RUN: one restoring-division step per edge:
  - partial remainder shifted left by 1, shifting in the next dividend bit MSB-first;
  - if remainder >= |b|, subtract |b| and set the quotient bit, else clear it.
  - Compare/subtract width is WIDTH+1 bits, so there is no overflow.
  - Counter increments each step. After step WIDTH-1 (the WIDTH-th edge in RUN), go to DONE.
- DONE: out_valid=1. lo = sign_q ? -q : q, and hi = sign_r ? -r : r. Both are registered at the DONE entry edge and stable while in DONE. On out_ready, go to IDLE at the next edge.
- Latency: if the accept handshake is sampled in cycle 0, out_valid first goes high in cycle WIDTH+1 (cycle 33 for WIDTH=32). This is fixed and data-independent, including divide-by-zero.
- Backpressure: DONE holds indefinitely with hi/lo unchanged until out_ready.
- in_ready is 0 in RUN and DONE. A new operation cannot overlap an undelivered result.
- Flush:
  - In RUN or DONE, flush sends the block to IDLE at the next edge and the result is discarded. out_valid is 0 from the next cycle; in_ready is 1 from the next cycle.
  - In IDLE, flush blocks acceptance in that cycle; flush has priority over in_valid.
  - flush and out_ready together in DONE: go to IDLE. Whether the consumer sees the transfer is the consumer's concern; the block does not re-present the result.
- Divide by zero (no trap):
  - DIVU: lo = all ones, hi = a.
  - DIV: lo = 0xFFFFFFFF if a >= 0, else 1; hi = a.
  - These are exactly the outputs of the algorithm above with |b|=0; no special-case logic is needed.
- Overflow case DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0. This is the natural result of the magnitude arithmetic.
- Reset asserted mid-RUN or in DONE: immediate return to the reset values. No result is produced.

Decomposition:
- Shared package:
  - div_state_t enum {DIV_IDLE, DIV_RUN, DIV_DONE};
  - div_req_t struct {op_signed, a, b};
  - div_resp_t struct {hi, lo}.
- The decoder's ALU_OP_DIV/ALU_OP_DIVU map to op_signed=1/0 in the execute stage, not inside this block.
- One natural sub-module: div_step. It is combinational: one restoring step taking (rem, dividend bit, divisor) and returning (next rem, quotient bit). The FSM, counter and sign fix-up live in hilo_divider.

Test Plan:
- DIVU a=100, b=7 accepted in cycle 0 -> out_valid first high in cycle 33; lo=14, hi=2; busy=1 in cycles 1..33.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU a=5, b=0 -> lo=0xFFFFFFFF, hi=5. DIV a=-8, b=0 -> lo=1, hi=0xFFFFFFF8.
- out_ready held low for 5 cycles after out_valid -> hi/lo/out_valid stable for all 5 cycles, in_ready=0; out_ready=1 -> in_ready=1 next cycle.
- flush in cycle 10 of RUN -> out_valid never asserts; in_ready=1 in cycle 11. A new DIVU 9/3 issued then -> lo=3, hi=0 after 33 cycles.
- resetn pulsed low mid-RUN (cycle 15) -> outputs at reset values immediately. flush and in_valid together in IDLE -> not accepted, in_ready stays 1, busy stays 0.
